iotdf: RTL and testbench

//  IoT data filter. Accepts a stream of 128-bit sensor samples, one byte per

---
 rtl/iotdf.sv | 157 +++++++++++++++
 tb/tb_iotdf.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iotdf.sv
// iotdf -- IoT data filter.
//
// Collects a byte-serial stream of 128-bit samples (16 bytes each, MSB byte
// first) and applies one of seven filters chosen by fn_sel. Samples form
// rounds of 8; round-based filters report when the 8th sample completes,
// per-sample filters report right after each sample completes. Every result
// is presented on iot_out with a single-cycle valid strobe.
//
// Ports:
//   clk      in   1    clock, rising edge
//   rst      in   1    synchronous active-high reset
//   in_en    in   1    iot_in holds a valid byte this cycle
//   iot_in   in   8    input byte, sample sent MSB byte first
//   fn_sel   in   3    filter select 1..7 (0 = accept input, no output)
//   busy     out  1    always 0, every byte is accepted
//   valid    out  1    one-cycle result strobe
//   iot_out  out  128  result data, held between strobes
//
// fn_sel: 1 round max, 2 round min, 3 round average, 4 extract-in-range,
//         5 exclude-range, 6 rising peak of round max, 7 falling peak of
//         round min. All comparisons are unsigned.

module iotdf #(
  parameter logic [127:0] F4_LOW  = 128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
  parameter logic [127:0] F4_HIGH = 128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
  parameter logic [127:0] F5_LOW  = 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
  parameter logic [127:0] F5_HIGH = 128'hBFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_en,
  input  logic [7:0]   iot_in,
  input  logic [2:0]   fn_sel,
  output logic         busy,
  output logic         valid,
  output logic [127:0] iot_out
);

  logic [3:0]   byte_cnt;
  logic [2:0]   smp_cnt;
  logic [119:0] shreg;
  logic [127:0] rnd_max;
  logic [127:0] rnd_min;
  logic [130:0] sum;
  logic [127:0] peak_max;
  logic [127:0] peak_min;

  logic [127:0] smp;
  logic [127:0] max_n;
  logic [127:0] min_n;
  logic [130:0] sum_n;
  logic         smp_done;
  logic         rnd_done;

  // The block never stalls the link.
  assign busy = 1'b0;

  // The completed sample is the 15 bytes already shifted in plus the byte
  // arriving now, so results can be registered on the 16th byte's edge.
  // The first sample of a round seeds the round accumulators directly,
  // which re-initialises round state without a separate clear cycle.
  always_comb begin
    smp      = {shreg, iot_in};
    smp_done = in_en && (byte_cnt == 4'd15);
    rnd_done = smp_done && (smp_cnt == 3'd7);
    if (smp_cnt == 3'd0) begin
      max_n = smp;
      min_n = smp;
      sum_n = {3'b000, smp};
    end else begin
      max_n = (smp > rnd_max) ? smp : rnd_max;
      min_n = (smp < rnd_min) ? smp : rnd_min;
      sum_n = sum + {3'b000, smp};
    end
  end

  // Byte assembly, round accumulation and filter decisions. valid defaults
  // low each cycle so any result is a single-cycle strobe; iot_out is only
  // written alongside valid and therefore holds its last value otherwise.
  // The 131-bit sum keeps eight all-ones samples from overflowing before the
  // divide-by-8, which is just dropping the low three bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= 4'd0;
      smp_cnt  <= 3'd0;
      shreg    <= '0;
      rnd_max  <= '0;
      rnd_min  <= '0;
      sum      <= '0;
      peak_max <= '0;
      peak_min <= '1;
      valid    <= 1'b0;
      iot_out  <= '0;
    end else begin
      valid <= 1'b0;
      if (in_en) begin
        byte_cnt <= byte_cnt + 4'd1;
        shreg    <= {shreg[111:0], iot_in};
      end
      if (smp_done) begin
        smp_cnt <= smp_cnt + 3'd1;
        rnd_max <= max_n;
        rnd_min <= min_n;
        sum     <= sum_n;
        case (fn_sel)
          3'd1: begin
            if (rnd_done) begin
              valid   <= 1'b1;
              iot_out <= max_n;
            end
          end
          3'd2: begin
            if (rnd_done) begin
              valid   <= 1'b1;
              iot_out <= min_n;
            end
          end
          3'd3: begin
            if (rnd_done) begin
              valid   <= 1'b1;
              iot_out <= sum_n[130:3];
            end
          end
          3'd4: begin
            if ((smp > F4_LOW) && (smp < F4_HIGH)) begin
              valid   <= 1'b1;
              iot_out <= smp;
            end
          end
          3'd5: begin
            if ((smp < F5_LOW) || (smp > F5_HIGH)) begin
              valid   <= 1'b1;
              iot_out <= smp;
            end
          end
          3'd6: begin
            if (rnd_done && (max_n > peak_max)) begin
              peak_max <= max_n;
              valid    <= 1'b1;
              iot_out  <= max_n;
            end
          end
          3'd7: begin
            if (rnd_done && (min_n < peak_min)) begin
              peak_min <= min_n;
              valid    <= 1'b1;
              iot_out  <= min_n;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iotdf.sv
// tb_iotdf -- self-checking bench for iotdf.
//
// A table of fixed vectors covers the documented examples and range
// boundaries, hand-written sequences cover output timing, peak tracking,
// input gaps and mid-round reset, and a randomized run per fn_sel is scored
// against a round-based reference model.

module tb_iotdf;

  localparam logic [127:0] ONES    = '1;
  localparam logic [127:0] F4_LOW  = 128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] F4_HIGH = 128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] F5_LOW  = 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] F5_HIGH = 128'hBFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_en;
  logic [7:0]   iot_in;
  logic [2:0]   fn_sel;
  logic         busy;
  logic         valid;
  logic [127:0] iot_out;

  int checks = 0;
  int errors = 0;

  logic [127:0] got_q[$];
  logic [127:0] exp_q[$];

  // Reference model state: samples of the current round and the two peaks.
  logic [127:0] m_rnd[$];
  logic [127:0] m_peak_max;
  logic [127:0] m_peak_min;

  typedef struct {
    logic [2:0]         fn;
    int                 n;
    logic [7:0][127:0]  smp;
    int                 exp_cnt;
    logic [127:0]       exp_val;
  } vec_t;

  vec_t vecs[12];

  iotdf dut (
    .clk     (clk),
    .rst     (rst),
    .in_en   (in_en),
    .iot_in  (iot_in),
    .fn_sel  (fn_sel),
    .busy    (busy),
    .valid   (valid),
    .iot_out (iot_out)
  );

  always #5 clk = ~clk;

  // Capture every result strobe away from the active edge.
  always @(negedge clk) begin
    if (valid) got_q.push_back(iot_out);
  end

  function automatic logic [7:0][127:0] seq18();
    logic [7:0][127:0] r;
    for (int i = 0; i < 8; i++) r[i] = 128'(i + 1);
    return r;
  endfunction

  function automatic logic [7:0][127:0] one(input logic [127:0] v);
    logic [7:0][127:0] r;
    r    = '0;
    r[0] = v;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Whole-round reference: max/min/average over the 8 stored samples,
  // peaks updated only on strict improvement.
  task automatic modelSample(input logic [127:0] s);
    logic [127:0] mx;
    logic [127:0] mn;
    logic [130:0] acc;
    if (fn_sel == 3'd4 && s > F4_LOW && s < F4_HIGH) exp_q.push_back(s);
    if (fn_sel == 3'd5 && (s < F5_LOW || s > F5_HIGH)) exp_q.push_back(s);
    m_rnd.push_back(s);
    if (m_rnd.size() == 8) begin
      mx  = '0;
      mn  = ONES;
      acc = '0;
      foreach (m_rnd[i]) begin
        if (m_rnd[i] > mx) mx = m_rnd[i];
        if (m_rnd[i] < mn) mn = m_rnd[i];
        acc = acc + {3'b000, m_rnd[i]};
      end
      case (fn_sel)
        3'd1: exp_q.push_back(mx);
        3'd2: exp_q.push_back(mn);
        3'd3: exp_q.push_back(acc[130:3]);
        3'd6: if (mx > m_peak_max) begin m_peak_max = mx; exp_q.push_back(mx); end
        3'd7: if (mn < m_peak_min) begin m_peak_min = mn; exp_q.push_back(mn); end
        default: ;
      endcase
      m_rnd.delete();
    end
  endtask

  task automatic idle(input int n);
    in_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst    = 1'b1;
    in_en  = 1'b0;
    iot_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    m_rnd.delete();
    m_peak_max = '0;
    m_peak_min = ONES;
  endtask

  // Send one sample MSB byte first, optionally with random idle gaps.
  task automatic applyStimulus(input logic [127:0] s, input int gap_max);
    for (int i = 0; i < 16; i++) begin
      if (gap_max > 0) idle($urandom_range(0, gap_max));
      in_en  = 1'b1;
      iot_in = s[127 - 8 * i -: 8];
      @(posedge clk);
      #1;
      in_en = 1'b0;
    end
    modelSample(s);
  endtask

  task automatic compareQueues(input string name);
    int n;
    idle(3);
    checkOutput($sformatf("%s count", name), 128'(got_q.size()), 128'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s result %0d", name, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    logic [127:0] bnd[6];
    logic [127:0] s;

    rst    = 1'b1;
    in_en  = 1'b0;
    iot_in = 8'h00;
    fn_sel = 3'd0;

    vecs[0]  = '{3'd1, 8, seq18(), 1, 128'h8};
    vecs[1]  = '{3'd2, 8, seq18(), 1, 128'h1};
    vecs[2]  = '{3'd3, 8, seq18(), 1, 128'h4};
    vecs[3]  = '{3'd3, 8, {8{ONES}}, 1, ONES};
    vecs[4]  = '{3'd4, 1, one(F4_LOW), 0, 128'h0};
    vecs[5]  = '{3'd4, 1, one(F4_HIGH), 0, 128'h0};
    vecs[6]  = '{3'd4, 1, one(128'h7000_0000_0000_0000_0000_0000_0000_0000), 1,
                 128'h7000_0000_0000_0000_0000_0000_0000_0000};
    vecs[7]  = '{3'd5, 1, one(F5_LOW), 0, 128'h0};
    vecs[8]  = '{3'd5, 1, one(F5_HIGH), 0, 128'h0};
    vecs[9]  = '{3'd5, 1, one(128'h0), 1, 128'h0};
    vecs[10] = '{3'd5, 1, one(128'hC000_0000_0000_0000_0000_0000_0000_0000), 1,
                 128'hC000_0000_0000_0000_0000_0000_0000_0000};
    vecs[11] = '{3'd0, 8, seq18(), 0, 128'h0};

    // Reset state.
    doReset();
    checkOutput("reset busy", 128'(busy), 128'h0);
    checkOutput("reset valid", 128'(valid), 128'h0);
    checkOutput("reset iot_out", iot_out, 128'h0);

    // Table-driven vectors, each from a fresh reset.
    for (int v = 0; v < 12; v++) begin
      doReset();
      fn_sel = vecs[v].fn;
      for (int j = 0; j < vecs[v].n; j++) applyStimulus(vecs[v].smp[j], 0);
      idle(3);
      checkOutput($sformatf("vec%0d count", v), 128'(got_q.size()), 128'(vecs[v].exp_cnt));
      if (vecs[v].exp_cnt > 0 && got_q.size() > 0)
        checkOutput($sformatf("vec%0d value", v), got_q[got_q.size() - 1], vecs[v].exp_val);
    end

    // F1 timing: strobe right after the 128th byte, one cycle wide, data held.
    doReset();
    fn_sel = 3'd1;
    for (int j = 1; j <= 8; j++) applyStimulus(128'(j), 0);
    checkOutput("f1 valid after last byte", 128'(valid), 128'h1);
    checkOutput("f1 data after last byte", iot_out, 128'h8);
    idle(1);
    checkOutput("f1 valid one cycle", 128'(valid), 128'h0);
    checkOutput("f1 data held", iot_out, 128'h8);

    // F6: round maxima 5,3,9 -> 5 then 9.
    doReset();
    fn_sel = 3'd6;
    for (int j = 0; j < 8; j++) applyStimulus(128'h5, 0);
    for (int j = 0; j < 8; j++) applyStimulus(128'h3, 0);
    for (int j = 0; j < 8; j++) applyStimulus(128'h9, 0);
    idle(3);
    checkOutput("f6 count", 128'(got_q.size()), 128'h2);
    if (got_q.size() >= 2) begin
      checkOutput("f6 first", got_q[0], 128'h5);
      checkOutput("f6 second", got_q[1], 128'h9);
    end

    // F7: round minima 5,7,2 -> 5 then 2.
    doReset();
    fn_sel = 3'd7;
    for (int j = 0; j < 8; j++) applyStimulus(128'h5, 0);
    for (int j = 0; j < 8; j++) applyStimulus(128'h7, 0);
    for (int j = 0; j < 8; j++) applyStimulus(128'h2, 0);
    idle(3);
    checkOutput("f7 count", 128'(got_q.size()), 128'h2);
    if (got_q.size() >= 2) begin
      checkOutput("f7 first", got_q[0], 128'h5);
      checkOutput("f7 second", got_q[1], 128'h2);
    end

    // Gaps in in_en do not change the result.
    doReset();
    fn_sel = 3'd3;
    for (int j = 1; j <= 8; j++) applyStimulus(128'(j), 3);
    idle(3);
    checkOutput("gap count", 128'(got_q.size()), 128'h1);
    if (got_q.size() > 0) checkOutput("gap value", got_q[0], 128'h4);

    // Reset mid-round and mid-sample: the zero samples must be forgotten.
    doReset();
    fn_sel = 3'd2;
    for (int j = 0; j < 3; j++) applyStimulus(128'h0, 0);
    for (int i = 0; i < 7; i++) begin
      in_en  = 1'b1;
      iot_in = 8'h00;
      @(posedge clk);
      #1;
    end
    doReset();
    for (int j = 1; j <= 8; j++) applyStimulus(128'(j), 0);
    idle(3);
    checkOutput("rst mid count", 128'(got_q.size()), 128'h1);
    if (got_q.size() > 0) checkOutput("rst mid value", got_q[0], 128'h1);

    // Randomized streams against the reference model, every fn_sel.
    bnd[0] = F4_LOW;
    bnd[1] = F4_HIGH;
    bnd[2] = F5_LOW;
    bnd[3] = F5_HIGH;
    bnd[4] = ONES;
    bnd[5] = '0;
    for (int f = 0; f < 8; f++) begin
      doReset();
      fn_sel = 3'(f);
      for (int k = 0; k < 24; k++) begin
        if ($urandom_range(0, 5) == 0) s = bnd[$urandom_range(0, 5)];
        else s = {$urandom(), $urandom(), $urandom(), $urandom()};
        applyStimulus(s, ($urandom_range(0, 3) == 0) ? 2 : 0);
      end
      compareQueues($sformatf("rand fn%0d", f));
      checkOutput($sformatf("rand fn%0d busy", f), 128'(busy), 128'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
